// File: rtl/memio_bridge_if.sv
// Core-side request/response and SRAM-side port of the memory/I-O bridge.
// The slave modport is the bridge; the master modport is the core plus SRAM environment.
interface memio_bridge_if;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_mem_ena;
  logic        cpu_wr_ena;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic [15:0] sram_addr;
  logic [15:0] sram_wdata;
  logic        sram_en;
  logic        sram_we;
  logic [15:0] sram_rdata;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_mem_ena, cpu_wr_ena, sram_rdata,
    output cpu_rdata, cpu_ready, sram_addr, sram_wdata, sram_en, sram_we
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_mem_ena, cpu_wr_ena, sram_rdata,
    input  cpu_rdata, cpu_ready, sram_addr, sram_wdata, sram_en, sram_we
  );
endinterface

// File: rtl/memio_bridge.sv
// SLC-3 memory/I-O bridge: one SRAM access or one switch/hex I/O access per core request,
// completed with a single-cycle cpu_ready pulse.
module memio_bridge #(
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic          clk,
  input  logic          reset,
  memio_bridge_if.slave bus,
  input  logic [15:0]   sw_i,
  output logic [15:0]   hex_o
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, RELEASE} state_t;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic        wr_q;
  logic [15:0] sw_s1, sw_s2;
  logic        is_io;

  assign is_io         = (bus.cpu_addr == IO_ADDR);
  assign bus.cpu_ready = (state == RESP);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cpu_mem_ena) state_nxt = is_io ? RESP : ACCESS;
      ACCESS:  if (cnt == 3'd0)     state_nxt = RESP;
      RESP:    state_nxt = bus.cpu_mem_ena ? RELEASE : IDLE;
      RELEASE: if (!bus.cpu_mem_ena) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured only at the IDLE acceptance edge, so later
  // changes on the core side cannot disturb an access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1          <= '0;
      sw_s2          <= '0;
      cnt            <= '0;
      wr_q           <= 1'b0;
      hex_o          <= '0;
      bus.cpu_rdata  <= '0;
      bus.sram_addr  <= '0;
      bus.sram_wdata <= '0;
      bus.sram_en    <= 1'b0;
      bus.sram_we    <= 1'b0;
    end else begin
      sw_s1       <= sw_i;
      sw_s2       <= sw_s1;
      bus.sram_en <= 1'b0;
      bus.sram_we <= 1'b0;
      case (state)
        IDLE: if (bus.cpu_mem_ena) begin
          wr_q <= bus.cpu_wr_ena;
          if (is_io) begin
            if (bus.cpu_wr_ena) hex_o         <= bus.cpu_wdata;
            else                bus.cpu_rdata <= sw_s2;
          end else begin
            bus.sram_addr  <= bus.cpu_addr;
            bus.sram_wdata <= bus.cpu_wdata;
            bus.sram_en    <= 1'b1;
            bus.sram_we    <= bus.cpu_wr_ena;
            cnt            <= WS;
          end
        end
        ACCESS: begin
          if (cnt == 3'd0) begin
            if (!wr_q) bus.cpu_rdata <= bus.sram_rdata;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_memio_bridge.sv
// Bench for memio_bridge: one WAIT_STATES=1 and one WAIT_STATES=3 bridge share the core
// side; each has its own SRAM model. Table-driven vectors plus reset corner sequences.
module tb_memio_bridge;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] addr = '0, wdata = '0, sw = '0;
  logic        ena = 1'b0, wr = 1'b0;
  logic [15:0] hex1, hex3;

  memio_bridge_if b1();
  memio_bridge_if b3();

  assign b1.cpu_addr = addr;  assign b3.cpu_addr = addr;
  assign b1.cpu_wdata = wdata; assign b3.cpu_wdata = wdata;
  assign b1.cpu_mem_ena = ena; assign b3.cpu_mem_ena = ena;
  assign b1.cpu_wr_ena = wr;   assign b3.cpu_wr_ena = wr;

  memio_bridge #(.WAIT_STATES(1), .IO_ADDR(16'hFFFF)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave), .sw_i(sw), .hex_o(hex1));
  memio_bridge #(.WAIT_STATES(3), .IO_ADDR(16'hFFFF)) dut3 (
    .clk(clk), .reset(reset), .bus(b3.slave), .sw_i(sw), .hex_o(hex3));

  // SRAM models: unwritten locations return a fixed address-derived pattern;
  // read data is only valid WAIT_STATES cycles after the enable edge.
  function automatic logic [15:0] dflt(input logic [15:0] a);
    case (a)
      16'h1234: return 16'h5A5A;
      16'hFFFE: return 16'hCAFE;
      default:  return a ^ 16'h6C6C;
    endcase
  endfunction

  logic [15:0] m1 [0:65535];
  logic [15:0] m3 [0:65535];
  bit          w1 [0:65535] = '{default: 1'b0};
  bit          w3 [0:65535] = '{default: 1'b0};
  logic [15:0] ra1 = '0, ra3 = '0;
  int          rc1 = 0, rc3 = 0;
  bit          rv1 = 1'b0, rv3 = 1'b0;

  always @(posedge clk) begin
    if (b1.sram_en) begin
      if (b1.sram_we) begin
        m1[b1.sram_addr] <= b1.sram_wdata;
        w1[b1.sram_addr] <= 1'b1;
      end else begin
        ra1 <= b1.sram_addr; rc1 <= 0; rv1 <= 1'b1;
      end
    end else if (rc1 != 0) rc1 <= rc1 - 1;
  end

  always @(posedge clk) begin
    if (b3.sram_en) begin
      if (b3.sram_we) begin
        m3[b3.sram_addr] <= b3.sram_wdata;
        w3[b3.sram_addr] <= 1'b1;
      end else begin
        ra3 <= b3.sram_addr; rc3 <= 2; rv3 <= 1'b1;
      end
    end else if (rc3 != 0) rc3 <= rc3 - 1;
  end

  assign b1.sram_rdata = (rv1 && rc1 == 0) ? (w1[ra1] ? m1[ra1] : dflt(ra1)) : 16'hDEAD;
  assign b3.sram_rdata = (rv3 && rc3 == 0) ? (w3[ra3] ? m3[ra3] : dflt(ra3)) : 16'hDEAD;

  // Pulse counters and captured SRAM command per bridge.
  int          en_n  [2] = '{0, 0};
  int          rdy_n [2] = '{0, 0};
  logic        last_we   [2] = '{1'b0, 1'b0};
  logic [15:0] last_addr [2] = '{16'h0, 16'h0};
  logic [15:0] last_wd   [2] = '{16'h0, 16'h0};

  always @(negedge clk) begin
    if (b1.sram_en) begin
      en_n[0] <= en_n[0] + 1; last_we[0] <= b1.sram_we;
      last_addr[0] <= b1.sram_addr; last_wd[0] <= b1.sram_wdata;
    end
    if (b3.sram_en) begin
      en_n[1] <= en_n[1] + 1; last_we[1] <= b3.sram_we;
      last_addr[1] <= b3.sram_addr; last_wd[1] <= b3.sram_wdata;
    end
    if (b1.cpu_ready) rdy_n[0] <= rdy_n[0] + 1;
    if (b3.cpu_ready) rdy_n[1] <= rdy_n[1] + 1;
  end

  function automatic logic rdy(input bit s);
    return s ? b3.cpu_ready : b1.cpu_ready;
  endfunction
  function automatic logic [15:0] rdat(input bit s);
    return s ? b3.cpu_rdata : b1.cpu_rdata;
  endfunction
  function automatic logic [15:0] hexv(input bit s);
    return s ? hex3 : hex1;
  endfunction

  int vecs = 0, errs = 0;

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          s;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [15:0] sw;
    logic [15:0] exp_rd;
    logic [15:0] exp_hex;
    int          lat;
    int          hold;
    int          exp_en;
  } vec_t;

  typedef struct {
    logic [15:0] rd;
    int          lat;
  } exp_t;

  exp_t sb[$];

  // Counts edges from request to the cpu_ready cycle; 40 marks a timeout.
  task automatic wait_rdy(input bit s, output int lat);
    lat = 1;
    @(negedge clk);
    while (!rdy(s) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    int   lat, en0, rd0;
    exp_t e;
    sw = v.sw;
    repeat (3) @(negedge clk);
    #1;
    en0 = en_n[v.s];
    rd0 = rdy_n[v.s];
    sb.push_back('{v.exp_rd, v.lat});
    addr = v.addr; wdata = v.wd; wr = v.wr; ena = 1'b1;
    // scramble the request after the acceptance edge; the bridge must ignore it
    @(posedge clk);
    #1;
    addr = ~v.addr; wdata = ~v.wd; wr = ~v.wr;
    wait_rdy(v.s, lat);
    e = sb.pop_front();
    chki({nm, " latency"}, lat, e.lat);
    if (!v.wr) chk16({nm, " rdata"}, rdat(v.s), e.rd);
    chk16({nm, " hex"}, hexv(v.s), v.exp_hex);
    repeat (v.hold) @(negedge clk);
    ena = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chki({nm, " sram_en pulses"}, en_n[v.s] - en0, v.exp_en);
    chki({nm, " ready pulses"}, rdy_n[v.s] - rd0, 1);
    if (v.exp_en == 1) begin
      chk16({nm, " sram_addr"}, last_addr[v.s], v.addr);
      chk16({nm, " sram_we"}, {15'h0, last_we[v.s]}, {15'h0, v.wr});
      if (v.wr) chk16({nm, " sram_wdata"}, last_wd[v.s], v.wd);
    end
  endtask

  vec_t tbl [12];

  initial begin
    int lat, rd0;
    //          s     wr    addr      wd        sw        exp_rd    exp_hex   lat hold en
    tbl[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 3, 0, 1};
    tbl[1]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 3, 0, 1};
    tbl[2]  = '{1'b1, 1'b0, 16'h1234, 16'h0000, 16'h0000, 16'h5A5A, 16'h0000, 5, 0, 1};
    tbl[3]  = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h1234, 16'h1234, 16'h0000, 1, 0, 0};
    tbl[4]  = '{1'b0, 1'b1, 16'hFFFF, 16'h00A5, 16'h1234, 16'h0000, 16'h00A5, 1, 0, 0};
    tbl[5]  = '{1'b0, 1'b0, 16'h1234, 16'h0000, 16'h1234, 16'h5A5A, 16'h00A5, 3, 5, 1};
    tbl[6]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234, 16'hBEEF, 16'h00A5, 3, 0, 1};
    tbl[7]  = '{1'b1, 1'b1, 16'h0020, 16'h1357, 16'h1234, 16'h0000, 16'h00A5, 5, 0, 1};
    tbl[8]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234, 16'h1357, 16'h00A5, 5, 2, 1};
    tbl[9]  = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0F0F, 16'h0F0F, 16'h00A5, 1, 0, 0};
    tbl[10] = '{1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'h0F0F, 16'hCAFE, 16'h00A5, 3, 0, 1};
    tbl[11] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0F0F, 16'hBEEF, 16'h00A5, 5, 0, 1};

    // Reset held two cycles with all switches high.
    sw = 16'hFFFF;
    repeat (2) @(negedge clk);
    chk16("rst cpu_rdata", b1.cpu_rdata, 16'h0);
    chk16("rst cpu_ready", {15'h0, b1.cpu_ready}, 16'h0);
    chk16("rst sram_addr", b1.sram_addr, 16'h0);
    chk16("rst sram_wdata", b1.sram_wdata, 16'h0);
    chk16("rst sram_en", {15'h0, b1.sram_en}, 16'h0);
    chk16("rst sram_we", {15'h0, b1.sram_we}, 16'h0);
    chk16("rst hex", hex1, 16'h0);
    chk16("rst ws3 ready", {15'h0, b3.cpu_ready}, 16'h0);
    chk16("rst ws3 rdata", b3.cpu_rdata, 16'h0);
    reset = 1'b0;

    // I/O read one cycle after release sees either synchronizer value.
    @(negedge clk);
    addr = 16'hFFFF; wr = 1'b0; ena = 1'b1;
    wait_rdy(1'b0, lat);
    chki("early io latency", lat, 1);
    vecs++;
    if (b1.cpu_rdata !== 16'h0 && b1.cpu_rdata !== 16'hFFFF) begin
      errs++;
      $display("FAIL early io rdata: got %h expected 0000 or ffff", b1.cpu_rdata);
    end
    ena = 1'b0;
    apply('{1'b0, 1'b0, 16'hFFFF, 16'h0, 16'hFFFF, 16'hFFFF, 16'h0, 1, 0, 0}, "sync io");

    for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset sampled at E0+1 of a WAIT_STATES=3 read: the access is abandoned.
    repeat (3) @(negedge clk);
    #1;
    rd0 = rdy_n[1];
    addr = 16'h1234; wr = 1'b0; ena = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chki("midrst ready pulses", rdy_n[1] - rd0, 0);
    chk16("midrst rdata", b3.cpu_rdata, 16'h0);
    chk16("midrst hex", hex3, 16'h0);
    chk16("midrst sram_en", {15'h0, b3.sram_en}, 16'h0);
    ena = 1'b0;
    reset = 1'b0;
    apply('{1'b1, 1'b0, 16'h1234, 16'h0, 16'h0F0F, 16'h5A5A, 16'h0, 5, 0, 1}, "post rst");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
